// File: rtl/processor_debug_cmd_arbiter.sv
// Two-port round-robin arbiter for the core debug command port, with core-halt
// ownership locking and a response timeout.
module processor_debug_cmd_arbiter #(
  parameter logic [15:0] P_TIMEOUT = 16'hFFFF
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ0_REQ,
  output logic        oREQ0_BUSY,
  input  logic [3:0]  iREQ0_COMMAND,
  input  logic [11:0] iREQ0_TARGET,
  input  logic [31:0] iREQ0_DATA,
  output logic        oREQ0_VALID,
  output logic        oREQ0_ERROR,
  output logic [31:0] oREQ0_DATA,
  input  logic        iREQ1_REQ,
  output logic        oREQ1_BUSY,
  input  logic [3:0]  iREQ1_COMMAND,
  input  logic [11:0] iREQ1_TARGET,
  input  logic [31:0] iREQ1_DATA,
  output logic        oREQ1_VALID,
  output logic        oREQ1_ERROR,
  output logic [31:0] oREQ1_DATA,
  output logic        oDEBUG_CMD_REQ,
  input  logic        iDEBUG_CMD_BUSY,
  output logic [3:0]  oDEBUG_CMD_COMMAND,
  output logic [11:0] oDEBUG_CMD_TARGET,
  output logic [31:0] oDEBUG_CMD_DATA,
  input  logic        iDEBUG_CMD_VALID,
  input  logic        iDEBUG_CMD_ERROR,
  input  logic [31:0] iDEBUG_CMD_DATA,
  output logic        oLOCK_VALID,
  output logic        oLOCK_OWNER
);

  localparam logic [3:0] CmdGoCore    = 4'h8;
  localparam logic [3:0] CmdIntGoCore = 4'h9;
  localparam logic [3:0] CmdStopCore  = 4'hF;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0][3:0]   cmd_q, cmd_d;
  logic [1:0][11:0]  tgt_q, tgt_d;
  logic [1:0][31:0]  dat_q, dat_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic              lock_valid_q, lock_valid_d;
  logic              lock_owner_q, lock_owner_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              dbg_req_q, dbg_req_d;
  logic [3:0]        dbg_cmd_q, dbg_cmd_d;
  logic [11:0]       dbg_tgt_q, dbg_tgt_d;
  logic [31:0]       dbg_dat_q, dbg_dat_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_dat_q, rsp_dat_d;

  logic [1:0]        req_in;
  logic [1:0][3:0]   cmd_in;
  logic [1:0][11:0]  tgt_in;
  logic [1:0][31:0]  dat_in;
  logic              sel;

  assign req_in = {iREQ1_REQ, iREQ0_REQ};
  assign cmd_in = {iREQ1_COMMAND, iREQ0_COMMAND};
  assign tgt_in = {iREQ1_TARGET, iREQ0_TARGET};
  assign dat_in = {iREQ1_DATA, iREQ0_DATA};

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    cmd_d        = cmd_q;
    tgt_d        = tgt_q;
    dat_d        = dat_q;
    last_d       = last_q;
    grant_d      = grant_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    cnt_d        = cnt_q;
    dbg_req_d    = dbg_req_q;
    dbg_cmd_d    = dbg_cmd_q;
    dbg_tgt_d    = dbg_tgt_q;
    dbg_dat_d    = dbg_dat_q;
    rsp_valid_d  = '0;
    rsp_err_d    = rsp_err_q;
    rsp_dat_d    = rsp_dat_q;
    sel          = 1'b0;

    for (int n = 0; n < 2; n++) begin
      if (req_in[n] && !pend_q[n]) begin
        pend_d[n] = 1'b1;
        cmd_d[n]  = cmd_in[n];
        tgt_d[n]  = tgt_in[n];
        dat_d[n]  = dat_in[n];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          // Last-grant only moves on a tie so alternation holds across contested rounds.
          sel = (&pend_q) ? ~last_q : pend_q[1];
          if (&pend_q) last_d = sel;
          grant_d = sel;
          if (lock_valid_q && (lock_owner_q != sel)) begin
            state_d          = StResp;
            rsp_valid_d[sel] = 1'b1;
            rsp_err_d        = 1'b1;
            rsp_dat_d        = '0;
            pend_d[sel]      = 1'b0;
          end else begin
            state_d   = StIssue;
            dbg_req_d = 1'b1;
            dbg_cmd_d = cmd_q[sel];
            dbg_tgt_d = tgt_q[sel];
            dbg_dat_d = dat_q[sel];
          end
        end
      end
      StIssue: begin
        if (!iDEBUG_CMD_BUSY) begin
          state_d   = StWait;
          dbg_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        if (iDEBUG_CMD_VALID) begin
          state_d              = StResp;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d            = iDEBUG_CMD_ERROR;
          rsp_dat_d            = iDEBUG_CMD_DATA;
          pend_d[grant_q]      = 1'b0;
        end else if ((P_TIMEOUT != 16'd0) && (cnt_d == P_TIMEOUT)) begin
          state_d              = StResp;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d            = 1'b1;
          rsp_dat_d            = '0;
          pend_d[grant_q]      = 1'b0;
        end
      end
      StResp: begin
        state_d = StIdle;
        // Rejected and timed-out commands carry error=1, so only real core successes move the lock.
        if (!rsp_err_q) begin
          if (cmd_q[grant_q] == CmdStopCore) begin
            lock_valid_d = 1'b1;
            lock_owner_d = grant_q;
          end else if ((cmd_q[grant_q] == CmdGoCore || cmd_q[grant_q] == CmdIntGoCore)
                       && lock_owner_q == grant_q) begin
            lock_valid_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q      <= StIdle;
      pend_q       <= '0;
      cmd_q        <= '0;
      tgt_q        <= '0;
      dat_q        <= '0;
      last_q       <= 1'b1;
      grant_q      <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      cnt_q        <= '0;
      dbg_req_q    <= 1'b0;
      dbg_cmd_q    <= '0;
      dbg_tgt_q    <= '0;
      dbg_dat_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_dat_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      cmd_q        <= cmd_d;
      tgt_q        <= tgt_d;
      dat_q        <= dat_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      cnt_q        <= cnt_d;
      dbg_req_q    <= dbg_req_d;
      dbg_cmd_q    <= dbg_cmd_d;
      dbg_tgt_q    <= dbg_tgt_d;
      dbg_dat_q    <= dbg_dat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_dat_q    <= rsp_dat_d;
    end
  end

  assign oREQ0_BUSY         = pend_q[0];
  assign oREQ1_BUSY         = pend_q[1];
  assign oREQ0_VALID        = rsp_valid_q[0];
  assign oREQ1_VALID        = rsp_valid_q[1];
  assign oREQ0_ERROR        = rsp_valid_q[0] & rsp_err_q;
  assign oREQ1_ERROR        = rsp_valid_q[1] & rsp_err_q;
  assign oREQ0_DATA         = rsp_valid_q[0] ? rsp_dat_q : '0;
  assign oREQ1_DATA         = rsp_valid_q[1] ? rsp_dat_q : '0;
  assign oDEBUG_CMD_REQ     = dbg_req_q;
  assign oDEBUG_CMD_COMMAND = dbg_cmd_q;
  assign oDEBUG_CMD_TARGET  = dbg_tgt_q;
  assign oDEBUG_CMD_DATA    = dbg_dat_q;
  assign oLOCK_VALID        = lock_valid_q;
  assign oLOCK_OWNER        = lock_owner_q;

endmodule

// File: tb/tb_processor_debug_cmd_arbiter.sv
// Directed bench for processor_debug_cmd_arbiter: responses are predicted into a
// queue at stimulus time and matched by a negedge monitor.
module tb_processor_debug_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  cmd0 = '0, cmd1 = '0;
  logic [11:0] tgt0 = '0, tgt1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic        busy0, busy1, v0, v1, e0, e1;
  logic [31:0] rd0, rd1;
  logic        dbg_req, lock_v, lock_o;
  logic [3:0]  dbg_cmd;
  logic [11:0] dbg_tgt;
  logic [31:0] dbg_dat;
  logic        core_busy = 1'b1, core_valid = 1'b0, core_err = 1'b0;
  logic [31:0] core_dat = '0;

  always #5 clk = ~clk;

  processor_debug_cmd_arbiter #(.P_TIMEOUT(16'd8)) dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iREQ0_REQ(req0), .oREQ0_BUSY(busy0), .iREQ0_COMMAND(cmd0), .iREQ0_TARGET(tgt0),
    .iREQ0_DATA(wd0), .oREQ0_VALID(v0), .oREQ0_ERROR(e0), .oREQ0_DATA(rd0),
    .iREQ1_REQ(req1), .oREQ1_BUSY(busy1), .iREQ1_COMMAND(cmd1), .iREQ1_TARGET(tgt1),
    .iREQ1_DATA(wd1), .oREQ1_VALID(v1), .oREQ1_ERROR(e1), .oREQ1_DATA(rd1),
    .oDEBUG_CMD_REQ(dbg_req), .iDEBUG_CMD_BUSY(core_busy), .oDEBUG_CMD_COMMAND(dbg_cmd),
    .oDEBUG_CMD_TARGET(dbg_tgt), .oDEBUG_CMD_DATA(dbg_dat), .iDEBUG_CMD_VALID(core_valid),
    .iDEBUG_CMD_ERROR(core_err), .iDEBUG_CMD_DATA(core_dat),
    .oLOCK_VALID(lock_v), .oLOCK_OWNER(lock_o)
  );

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   vecs = 0;
  int   errs = 0;
  int   req_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_port(input logic p, input logic v, input logic e, input logic [31:0] d,
                          input logic b);
    rsp_t r;
    if (v) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {31'd0, v}, 32'd0);
      end else begin
        r = exp_q.pop_front();
        chk("rsp_port", {31'd0, p}, {31'd0, r.port});
        chk("rsp_err", {31'd0, e}, {31'd0, r.err});
        chk("rsp_data", d, r.data);
        chk("busy_at_valid", {31'd0, b}, 32'd0);
      end
    end else begin
      chk("idle_rsp_zero", {31'd0, e} | d, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dbg_req) req_cycles++;
      mon_port(1'b0, v0, e0, rd0, busy0);
      mon_port(1'b1, v1, e1, rd1, busy1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic p, input logic e, input logic [31:0] d);
    exp_q.push_back(rsp_t'{port: p, err: e, data: d});
  endtask

  task automatic send(input logic p, input logic [3:0] c, input logic [11:0] t,
                      input logic [31:0] d);
    int n = 0;
    while ((p ? busy1 : busy0) && n < 200) begin tick(); n++; end
    chk("send_bound", {31'd0, (n < 200)}, 32'd1);
    if (p) begin req1 = 1'b1; cmd1 = c; tgt1 = t; wd1 = d; end
    else   begin req0 = 1'b1; cmd0 = c; tgt0 = t; wd0 = d; end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic core_accept(input int nbusy, input logic [3:0] ecmd, input logic [11:0] etgt);
    int n = 0;
    while (!dbg_req && n < 50) begin tick(); n++; end
    chk("core_req_seen", {31'd0, dbg_req}, 32'd1);
    chk("core_cmd", {28'd0, dbg_cmd}, {28'd0, ecmd});
    chk("core_tgt", {20'd0, dbg_tgt}, {20'd0, etgt});
    repeat (nbusy) tick();
    core_busy = 1'b0;
    tick();
    core_busy = 1'b1;
  endtask

  task automatic core_respond(input int lat, input logic err, input logic [31:0] d);
    repeat (lat - 1) tick();
    core_valid = 1'b1;
    core_err   = err;
    core_dat   = d;
    tick();
    core_valid = 1'b0;
    core_err   = 1'b0;
    core_dat   = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain", exp_q.size(), 32'd0);
    tick();
  endtask

  int rc;

  initial begin
    repeat (3) tick();
    chk("reset_outs", {31'd0, |{busy0, busy1, v0, v1, e0, e1, rd0, rd1, dbg_req, dbg_cmd,
                                dbg_tgt, dbg_dat, lock_v, lock_o}}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Port 0 READ_REG with a slow core
    expect_rsp(1'b0, 1'b0, 32'h1234_5678);
    rc = req_cycles;
    send(1'b0, 4'h0, 12'd5, 32'd0);
    chk("t1_busy_rise", {31'd0, busy0}, 32'd1);
    core_accept(3, 4'h0, 12'd5);
    core_respond(4, 1'b0, 32'h1234_5678);
    chk("t1_valid", {31'd0, v0}, 32'd1);
    chk("t1_data", rd0, 32'h1234_5678);
    chk("t1_busy_fall", {31'd0, busy0}, 32'd0);
    tick();
    chk("t1_req_cycles", req_cycles - rc, 32'd4);
    drain();

    // Simultaneous requests: port 0 first, then port 1 first next round
    req0 = 1'b1; cmd0 = 4'h0; tgt0 = 12'h010;
    req1 = 1'b1; cmd1 = 4'h0; tgt1 = 12'h020;
    expect_rsp(1'b0, 1'b0, 32'hA0A0_0001);
    expect_rsp(1'b1, 1'b0, 32'hB0B0_0002);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    core_accept(0, 4'h0, 12'h010);
    core_respond(1, 1'b0, 32'hA0A0_0001);
    core_accept(0, 4'h0, 12'h020);
    core_respond(2, 1'b0, 32'hB0B0_0002);
    drain();
    req0 = 1'b1; cmd0 = 4'h0; tgt0 = 12'h011;
    req1 = 1'b1; cmd1 = 4'h0; tgt1 = 12'h021;
    expect_rsp(1'b1, 1'b0, 32'hB0B0_0003);
    expect_rsp(1'b0, 1'b0, 32'hA0A0_0004);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    core_accept(0, 4'h0, 12'h021);
    core_respond(1, 1'b0, 32'hB0B0_0003);
    core_accept(0, 4'h0, 12'h011);
    core_respond(1, 1'b0, 32'hA0A0_0004);
    drain();

    // Lock ownership by port 1
    expect_rsp(1'b1, 1'b0, 32'd0);
    send(1'b1, 4'hF, 12'd0, 32'd0);
    core_accept(0, 4'hF, 12'd0);
    core_respond(2, 1'b0, 32'd0);
    drain();
    chk("t3_lock_set", {30'd0, lock_v, lock_o}, 32'd3);
    rc = req_cycles;
    expect_rsp(1'b0, 1'b1, 32'd0);
    send(1'b0, 4'h1, 12'd7, 32'hDEAD_BEEF);
    drain();
    chk("t3_no_core_req", req_cycles - rc, 32'd0);
    chk("t3_lock_kept", {31'd0, lock_v}, 32'd1);
    expect_rsp(1'b1, 1'b0, 32'd0);
    send(1'b1, 4'h8, 12'd0, 32'd0);
    core_accept(0, 4'h8, 12'd0);
    core_respond(1, 1'b0, 32'd0);
    drain();
    chk("t3_lock_clear", {31'd0, lock_v}, 32'd0);
    expect_rsp(1'b0, 1'b0, 32'h0000_00C3);
    send(1'b0, 4'h1, 12'd7, 32'h0000_00C3);
    core_accept(0, 4'h1, 12'd7);
    core_respond(1, 1'b0, 32'h0000_00C3);
    drain();

    // Timeout after 8 WAIT cycles, then a late core response is dropped
    expect_rsp(1'b0, 1'b1, 32'd0);
    send(1'b0, 4'h0, 12'd3, 32'd0);
    core_accept(0, 4'h0, 12'd3);
    repeat (7) tick();
    chk("t4_not_early", {31'd0, v0}, 32'd0);
    tick();
    chk("t4_timeout_valid", {31'd0, v0}, 32'd1);
    chk("t4_timeout_err", {31'd0, e0}, 32'd1);
    tick();
    core_valid = 1'b1; core_dat = 32'h5555_5555;
    tick();
    core_valid = 1'b0; core_dat = '0;
    repeat (5) tick();
    chk("t4_no_second", {31'd0, v0}, 32'd0);
    drain();

    // Core error on STOP_CORE leaves the lock clear
    expect_rsp(1'b0, 1'b1, 32'h0000_0BAD);
    send(1'b0, 4'hF, 12'd0, 32'd0);
    core_accept(1, 4'hF, 12'd0);
    core_respond(1, 1'b1, 32'h0000_0BAD);
    drain();
    chk("t5_no_lock", {31'd0, lock_v}, 32'd0);

    // Reset during WAIT while locked
    expect_rsp(1'b1, 1'b0, 32'd0);
    send(1'b1, 4'hF, 12'd0, 32'd0);
    core_accept(0, 4'hF, 12'd0);
    core_respond(1, 1'b0, 32'd0);
    drain();
    chk("t6_locked", {31'd0, lock_v}, 32'd1);
    send(1'b1, 4'h0, 12'd9, 32'd0);
    core_accept(0, 4'h0, 12'd9);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {31'd0, |{busy0, busy1, v0, v1, e0, e1, rd0, rd1, dbg_req, dbg_cmd,
                                 dbg_tgt, dbg_dat, lock_v, lock_o}}, 32'd0);
    core_valid = 1'b1; core_dat = 32'h7777_7777;
    tick();
    core_valid = 1'b0; core_dat = '0;
    rst_n = 1'b1;
    tick();
    chk("t6_lock_after", {30'd0, lock_v, lock_o}, 32'd0);
    expect_rsp(1'b0, 1'b0, 32'hCAFE_F00D);
    send(1'b0, 4'h0, 12'd10, 32'd0);
    core_accept(1, 4'h0, 12'd10);
    core_respond(3, 1'b0, 32'hCAFE_F00D);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
